// File: rtl/axi_arb_pkg.sv
// Shared state codes and address decode for the AXI bridge arbiter.
// The numeric state codes are also consumed by the bridge mux and the return path.
package axi_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE              = 4'd0,
    ST_RD_ADDR_M1        = 4'd1,
    ST_RD_DATA_M1S0      = 4'd2,
    ST_RD_DATA_M1S1      = 4'd3,
    ST_RD_ADDR_M0        = 4'd4,
    ST_RD_DATA_M0S0      = 4'd5,
    ST_RD_DATA_M0S1      = 4'd6,
    ST_WR_ADDR_M1        = 4'd7,
    ST_WR_DATA_M1S0      = 4'd8,
    ST_WR_DATA_M1S1      = 4'd9,
    ST_WR_RESP_S0M1      = 4'd10,
    ST_WR_RESP_S1M1      = 4'd11,
    ST_WR_ADDR_M0        = 4'd12,
    ST_DEFAULT_SLAVE     = 4'd13,
    ST_WR_ADDR_DATA_M1S0 = 4'd14,
    ST_WR_ADDR_DATA_M1S1 = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    SLV_S0  = 2'd0,
    SLV_S1  = 2'd1,
    SLV_DEF = 2'd2
  } slave_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

  localparam logic [31:0] SLAVE_WIN_SIZE = 32'h0001_0000;

  // Unsigned offset compare: addresses below a base wrap to huge offsets and miss.
  function automatic slave_e decode_slave(input logic [31:0] addr,
                                          input logic [31:0] s0_base,
                                          input logic [31:0] s1_base);
    logic [31:0] off0;
    logic [31:0] off1;
    off0 = addr - s0_base;
    off1 = addr - s1_base;
    if (off0 < SLAVE_WIN_SIZE)      return SLV_S0;
    else if (off1 < SLAVE_WIN_SIZE) return SLV_S1;
    else                            return SLV_DEF;
  endfunction

endpackage

// File: rtl/axi_arbiter_fsm_if.sv
// Handshake bundle between the masters/slaves and the arbiter FSMs.
// The arbiter sits on the slave modport; stimulus/upstream logic uses master.
interface axi_arbiter_fsm_if;
  logic        ARVALID_M0;
  logic        ARVALID_M1;
  logic [31:0] ARADDR_M0;
  logic [31:0] ARADDR_M1;
  logic        ARREADY;
  logic        RVALID;
  logic        RLAST;
  logic        RREADY;
  logic        AWVALID_M1;
  logic [31:0] AWADDR_M1;
  logic        WVALID_M1;
  logic        AWREADY;
  logic        WREADY;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  CS_R;
  logic [3:0]  NS_R;
  logic [3:0]  CS_W;
  logic [3:0]  NS_W;

  modport master (
    output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARREADY,
           RVALID, RLAST, RREADY, AWVALID_M1, AWADDR_M1, WVALID_M1,
           AWREADY, WREADY, WLAST, BVALID, BREADY,
    input  CS_R, NS_R, CS_W, NS_W
  );

  modport slave (
    input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARREADY,
           RVALID, RLAST, RREADY, AWVALID_M1, AWADDR_M1, WVALID_M1,
           AWREADY, WREADY, WLAST, BVALID, BREADY,
    output CS_R, NS_R, CS_W, NS_W
  );
endinterface

// File: rtl/axi_rd_rr_grant.sv
// Two-way round-robin picker for the read channel.
// History only advances on a real contention, so a lone requester never steals a turn.
module axi_rd_rr_grant
  import axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_m0,
  input  logic   req_m1,
  input  logic   take,
  output grant_e grant
);

  grant_e last_rd_grant;

  always_comb begin
    grant = GNT_M1;
    if (req_m0 && req_m1)
      grant = (last_rd_grant == GNT_M1) ? GNT_M0 : GNT_M1;
    else if (req_m0)
      grant = GNT_M0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_rd_grant <= GNT_M1;
    else if (take && req_m0 && req_m1)
      last_rd_grant <= grant;
  end

endmodule

// File: rtl/axi_arbiter_fsm.sv
// Read and write arbitration FSMs for the AXI bridge; state codes are exported
// so the mux and return path can steer channels directly from them.
module axi_arbiter_fsm
  import axi_arb_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic             ACLK,
  input  logic             ARESET,
  axi_arbiter_fsm_if.slave bus
);

  state_e rd_cs, rd_ns;
  state_e wr_cs, wr_ns;
  grant_e rd_grant;
  logic   rd_take;
  slave_e ar_slv_m0, ar_slv_m1, aw_slv;

  assign ar_slv_m0 = decode_slave(bus.ARADDR_M0, S0_BASE, S1_BASE);
  assign ar_slv_m1 = decode_slave(bus.ARADDR_M1, S0_BASE, S1_BASE);
  assign aw_slv    = decode_slave(bus.AWADDR_M1, S0_BASE, S1_BASE);

  axi_rd_rr_grant u_rr (
    .clk    (ACLK),
    .rst    (ARESET),
    .req_m0 (bus.ARVALID_M0),
    .req_m1 (bus.ARVALID_M1),
    .take   (rd_take),
    .grant  (rd_grant)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_cs <= ST_IDLE;
      wr_cs <= ST_IDLE;
    end else begin
      rd_cs <= rd_ns;
      wr_cs <= wr_ns;
    end
  end

  always_comb begin
    rd_ns = rd_cs;
    case (rd_cs)
      ST_IDLE:
        if (bus.ARVALID_M0 || bus.ARVALID_M1)
          rd_ns = (rd_grant == GNT_M0) ? ST_RD_ADDR_M0 : ST_RD_ADDR_M1;
      ST_RD_ADDR_M0:
        if (bus.ARVALID_M0 && bus.ARREADY) begin
          case (ar_slv_m0)
            SLV_S0:  rd_ns = ST_RD_DATA_M0S0;
            SLV_S1:  rd_ns = ST_RD_DATA_M0S1;
            default: rd_ns = ST_DEFAULT_SLAVE;
          endcase
        end
      ST_RD_ADDR_M1:
        if (bus.ARVALID_M1 && bus.ARREADY) begin
          case (ar_slv_m1)
            SLV_S0:  rd_ns = ST_RD_DATA_M1S0;
            SLV_S1:  rd_ns = ST_RD_DATA_M1S1;
            default: rd_ns = ST_DEFAULT_SLAVE;
          endcase
        end
      ST_RD_DATA_M0S0, ST_RD_DATA_M0S1, ST_RD_DATA_M1S0, ST_RD_DATA_M1S1,
      ST_DEFAULT_SLAVE:
        if (bus.RVALID && bus.RREADY && bus.RLAST)
          rd_ns = ST_IDLE;
      default: rd_ns = ST_IDLE;
    endcase
  end

  // W beats offered before the address is accepted are deliberately ignored.
  always_comb begin
    wr_ns = wr_cs;
    case (wr_cs)
      ST_IDLE:
        if (bus.AWVALID_M1 && bus.WVALID_M1) begin
          case (aw_slv)
            SLV_S0:  wr_ns = ST_WR_ADDR_DATA_M1S0;
            SLV_S1:  wr_ns = ST_WR_ADDR_DATA_M1S1;
            default: wr_ns = ST_DEFAULT_SLAVE;
          endcase
        end else if (bus.AWVALID_M1) begin
          wr_ns = ST_WR_ADDR_M1;
        end
      ST_WR_ADDR_M1:
        if (bus.AWVALID_M1 && bus.AWREADY) begin
          case (aw_slv)
            SLV_S0:  wr_ns = ST_WR_DATA_M1S0;
            SLV_S1:  wr_ns = ST_WR_DATA_M1S1;
            default: wr_ns = ST_DEFAULT_SLAVE;
          endcase
        end
      ST_WR_ADDR_DATA_M1S0:
        if (bus.AWREADY && bus.WREADY && bus.WLAST) wr_ns = ST_WR_RESP_S0M1;
        else if (bus.AWREADY)                       wr_ns = ST_WR_DATA_M1S0;
      ST_WR_ADDR_DATA_M1S1:
        if (bus.AWREADY && bus.WREADY && bus.WLAST) wr_ns = ST_WR_RESP_S1M1;
        else if (bus.AWREADY)                       wr_ns = ST_WR_DATA_M1S1;
      ST_WR_DATA_M1S0:
        if (bus.WVALID_M1 && bus.WREADY && bus.WLAST) wr_ns = ST_WR_RESP_S0M1;
      ST_WR_DATA_M1S1:
        if (bus.WVALID_M1 && bus.WREADY && bus.WLAST) wr_ns = ST_WR_RESP_S1M1;
      ST_WR_RESP_S0M1, ST_WR_RESP_S1M1, ST_DEFAULT_SLAVE:
        if (bus.BVALID && bus.BREADY) wr_ns = ST_IDLE;
      default: wr_ns = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_take  = (rd_cs == ST_IDLE);
    bus.CS_R = rd_cs;
    bus.NS_R = rd_ns;
    bus.CS_W = wr_cs;
    bus.NS_W = wr_ns;
  end

endmodule

// File: tb/tb_axi_arbiter_fsm.sv
// Directed plus randomized check of the arbiter FSMs against a transaction-level model.
module tb_axi_arbiter_fsm;

  logic ACLK;
  logic ARESET;
  int   checks = 0;
  int   errors = 0;

  axi_arbiter_fsm_if bus ();

  axi_arbiter_fsm dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Model: read owner (0/1), phase (0 idle, 1 address, 2 data), target (0 S0, 1 S1, 2 default).
  // Write phase: 0 idle, 1 addr only, 2 addr+data, 3 data, 4 resp, 5 default slave.
  int m_rd_owner, m_rd_phase, m_rd_tgt, m_last;
  int m_wr_phase, m_wr_tgt;
  int n_rd_owner, n_rd_phase, n_rd_tgt, n_last;
  int n_wr_phase, n_wr_tgt;

  function automatic int region(input logic [31:0] addr);
    if (addr < 32'h0001_0000) return 0;
    if (addr < 32'h0002_0000) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] rd_code(input int owner, input int phase, input int tgt);
    int c;
    if (phase == 0)      c = 0;
    else if (phase == 1) c = (owner == 0) ? 4 : 1;
    else if (tgt == 2)   c = 13;
    else                 c = ((owner == 0) ? 5 : 2) + tgt;
    return 4'(c);
  endfunction

  function automatic logic [3:0] wr_code(input int phase, input int tgt);
    int c;
    case (phase)
      0: c = 0;
      1: c = 7;
      2: c = 14 + tgt;
      3: c = 8 + tgt;
      4: c = 10 + tgt;
      default: c = 13;
    endcase
    return 4'(c);
  endfunction

  task automatic model_reset();
    m_rd_owner = 0; m_rd_phase = 0; m_rd_tgt = 0; m_last = 1;
    m_wr_phase = 0; m_wr_tgt = 0;
  endtask

  task automatic model_next();
    int g;
    logic v;
    logic [31:0] a;
    n_rd_owner = m_rd_owner; n_rd_phase = m_rd_phase; n_rd_tgt = m_rd_tgt; n_last = m_last;
    n_wr_phase = m_wr_phase; n_wr_tgt = m_wr_tgt;
    if (m_rd_phase == 0) begin
      if (bus.ARVALID_M0 || bus.ARVALID_M1) begin
        if (bus.ARVALID_M0 && bus.ARVALID_M1) begin
          g = (m_last == 0) ? 1 : 0;
          n_last = g;
        end else begin
          g = bus.ARVALID_M0 ? 0 : 1;
        end
        n_rd_owner = g;
        n_rd_phase = 1;
      end
    end else if (m_rd_phase == 1) begin
      v = (m_rd_owner == 0) ? bus.ARVALID_M0 : bus.ARVALID_M1;
      a = (m_rd_owner == 0) ? bus.ARADDR_M0 : bus.ARADDR_M1;
      if (v && bus.ARREADY) begin
        n_rd_phase = 2;
        n_rd_tgt   = region(a);
      end
    end else if (bus.RVALID && bus.RREADY && bus.RLAST) begin
      n_rd_phase = 0;
    end

    case (m_wr_phase)
      0: if (bus.AWVALID_M1 && bus.WVALID_M1) begin
           n_wr_tgt   = region(bus.AWADDR_M1);
           n_wr_phase = (n_wr_tgt == 2) ? 5 : 2;
         end else if (bus.AWVALID_M1) begin
           n_wr_phase = 1;
         end
      1: if (bus.AWVALID_M1 && bus.AWREADY) begin
           n_wr_tgt   = region(bus.AWADDR_M1);
           n_wr_phase = (n_wr_tgt == 2) ? 5 : 3;
         end
      2: if (bus.AWREADY && bus.WREADY && bus.WLAST) n_wr_phase = 4;
         else if (bus.AWREADY)                       n_wr_phase = 3;
      3: if (bus.WVALID_M1 && bus.WREADY && bus.WLAST) n_wr_phase = 4;
      default: if (bus.BVALID && bus.BREADY) n_wr_phase = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are already set (just after a rising edge); check NS, clock, check CS.
  task automatic cycle();
    #1;
    model_next();
    chk("ns_r", bus.NS_R, rd_code(n_rd_owner, n_rd_phase, n_rd_tgt));
    chk("ns_w", bus.NS_W, wr_code(n_wr_phase, n_wr_tgt));
    @(posedge ACLK);
    #1;
    m_rd_owner = n_rd_owner; m_rd_phase = n_rd_phase; m_rd_tgt = n_rd_tgt; m_last = n_last;
    m_wr_phase = n_wr_phase; m_wr_tgt = n_wr_tgt;
    chk("cs_r", bus.CS_R, rd_code(m_rd_owner, m_rd_phase, m_rd_tgt));
    chk("cs_w", bus.CS_W, wr_code(m_wr_phase, m_wr_tgt));
  endtask

  task automatic clear_inputs();
    bus.ARVALID_M0 = 0; bus.ARVALID_M1 = 0;
    bus.ARADDR_M0 = '0; bus.ARADDR_M1 = '0; bus.ARREADY = 0;
    bus.RVALID = 0; bus.RLAST = 0; bus.RREADY = 0;
    bus.AWVALID_M1 = 0; bus.AWADDR_M1 = '0; bus.WVALID_M1 = 0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.WLAST = 0;
    bus.BVALID = 0; bus.BREADY = 0;
  endtask

  logic [31:0] addr_pool [7] = '{32'h0000_0010, 32'h0000_FFFF, 32'h0001_0000,
                                 32'h0001_0004, 32'h0001_FFFF, 32'h0002_0000,
                                 32'h0005_0000};

  initial begin
    clear_inputs();
    model_reset();
    ARESET = 1'b1;
    #12;
    chk("reset_cs_r", bus.CS_R, 4'd0);
    chk("reset_cs_w", bus.CS_W, 4'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Single M0 read to S0, ARREADY on the second cycle, 4-beat burst.
    bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0010;
    cycle(); chk("m0_addr", bus.CS_R, 4'd4);
    bus.ARREADY = 1;
    cycle(); chk("m0_data_s0", bus.CS_R, 4'd5);
    bus.ARVALID_M0 = 0; bus.ARREADY = 0;
    bus.RVALID = 1; bus.RREADY = 1; bus.RLAST = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("burst_hold", bus.CS_R, 4'd5);
    end
    bus.RLAST = 1;
    cycle(); chk("burst_done", bus.CS_R, 4'd0);

    // Both masters held: grants alternate M0, M1, M0.
    bus.ARVALID_M0 = 1; bus.ARVALID_M1 = 1;
    bus.ARADDR_M0 = 32'h0000_0010; bus.ARADDR_M1 = 32'h0001_0004;
    bus.ARREADY = 1; bus.RVALID = 1; bus.RREADY = 1; bus.RLAST = 1;
    cycle(); chk("rr_first_m0", bus.CS_R, 4'd4);
    cycle(); cycle();
    cycle(); chk("rr_second_m1", bus.CS_R, 4'd1);
    cycle(); cycle();
    cycle(); chk("rr_third_m0", bus.CS_R, 4'd4);
    cycle();
    bus.ARVALID_M0 = 0; bus.ARVALID_M1 = 0;
    cycle(); chk("rr_back_idle", bus.CS_R, 4'd0);

    // M1 to S1, then M1 to an unmapped address.
    bus.ARVALID_M1 = 1; bus.ARADDR_M1 = 32'h0001_0004; bus.RVALID = 0;
    cycle(); cycle(); chk("m1_data_s1", bus.CS_R, 4'd3);
    bus.ARVALID_M1 = 0; bus.RVALID = 1;
    cycle(); chk("m1_s1_done", bus.CS_R, 4'd0);
    bus.ARVALID_M1 = 1; bus.ARADDR_M1 = 32'h0005_0000; bus.RVALID = 0;
    cycle(); cycle(); chk("m1_default", bus.CS_R, 4'd13);
    bus.ARVALID_M1 = 0; bus.RVALID = 1; bus.RLAST = 0;
    cycle(); chk("default_hold", bus.CS_R, 4'd13);
    bus.RLAST = 1;
    cycle(); chk("default_exit", bus.CS_R, 4'd0);
    clear_inputs();

    // Write with address and single data beat accepted together.
    bus.AWVALID_M1 = 1; bus.WVALID_M1 = 1; bus.AWADDR_M1 = 32'h0000_0100;
    cycle(); chk("wr_ad_s0", bus.CS_W, 4'd14);
    bus.AWREADY = 1; bus.WREADY = 1; bus.WLAST = 1;
    cycle(); chk("wr_resp_s0", bus.CS_W, 4'd10);
    bus.AWVALID_M1 = 0; bus.WVALID_M1 = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.WLAST = 0;
    bus.BVALID = 1; bus.BREADY = 1;
    cycle(); chk("wr_s0_done", bus.CS_W, 4'd0);
    clear_inputs();

    // Address-only write to S1, 2-beat burst, delayed response.
    bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h0001_0000; bus.AWREADY = 1;
    cycle(); chk("wr_addr", bus.CS_W, 4'd7);
    cycle(); chk("wr_data_s1", bus.CS_W, 4'd9);
    bus.AWVALID_M1 = 0; bus.AWREADY = 0;
    bus.WVALID_M1 = 1; bus.WREADY = 1; bus.WLAST = 0;
    cycle(); chk("wr_beat1", bus.CS_W, 4'd9);
    bus.WLAST = 1;
    cycle(); chk("wr_resp_s1", bus.CS_W, 4'd11);
    bus.WVALID_M1 = 0; bus.WREADY = 0; bus.WLAST = 0; bus.BREADY = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(); chk("bresp_wait", bus.CS_W, 4'd11);
    end
    bus.BVALID = 1;
    cycle(); chk("wr_s1_done", bus.CS_W, 4'd0);
    clear_inputs();

    // Reset in the middle of a read and a write.
    bus.ARVALID_M0 = 1; bus.ARADDR_M0 = 32'h0000_0010; bus.ARREADY = 1;
    bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h0001_0000; bus.AWREADY = 1;
    cycle(); cycle();
    chk("pre_rst_r", bus.CS_R, 4'd5);
    chk("pre_rst_w", bus.CS_W, 4'd9);
    clear_inputs();
    #2;
    ARESET = 1'b1;
    #1;
    chk("async_rst_r", bus.CS_R, 4'd0);
    chk("async_rst_w", bus.CS_W, 4'd0);
    model_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    bus.ARVALID_M0 = 1; bus.ARVALID_M1 = 1;
    cycle(); chk("post_rst_m0", bus.CS_R, 4'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.ARVALID_M0 = 1'($urandom_range(0, 1));
      bus.ARVALID_M1 = 1'($urandom_range(0, 1));
      bus.ARADDR_M0  = addr_pool[$urandom_range(0, 6)];
      bus.ARADDR_M1  = addr_pool[$urandom_range(0, 6)];
      bus.ARREADY    = 1'($urandom_range(0, 1));
      bus.RVALID     = 1'($urandom_range(0, 1));
      bus.RREADY     = 1'($urandom_range(0, 1));
      bus.RLAST      = 1'($urandom_range(0, 1));
      bus.AWVALID_M1 = 1'($urandom_range(0, 1));
      bus.AWADDR_M1  = addr_pool[$urandom_range(0, 6)];
      bus.WVALID_M1  = 1'($urandom_range(0, 1));
      bus.AWREADY    = 1'($urandom_range(0, 1));
      bus.WREADY     = 1'($urandom_range(0, 1));
      bus.WLAST      = 1'($urandom_range(0, 1));
      bus.BVALID     = 1'($urandom_range(0, 1));
      bus.BREADY     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_fsm.md
Name: axi_arbiter_fsm

Overview:
- Upstream control stage of the AXI bridge. Arbitrates read requests from masters M0 and M1, and write requests from M1.
- Runs two independent FSMs (read, write) and exports their current/next-state codes CS_R/NS_R/CS_W/NS_W.
- The master-to-slave mux and the slave-to-master return path both steer their channels from these codes.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 base address (64 KiB window)
- S1_BASE, 32'h0001_0000, slave 1 base address (64 KiB window)
- Any address outside both windows decodes to the default slave.

Ports:
- ACLK  in  1  bus clock.
- ARESET  in  1  asynchronous, active-high reset.
- ARVALID_M0, ARVALID_M1  in  1  raw master read-address valids.
- ARADDR_M0, ARADDR_M1  in  32  raw master read addresses.
- ARREADY  in  1  ready from the addressed slave.
- RVALID, RLAST  in  1  returned read-data handshake signals.
- RREADY  in  1  muxed master RREADY.
- AWVALID_M1  in  1  raw M1 write-address valid.
- AWADDR_M1  in  32  raw M1 write address.
- WVALID_M1  in  1  raw M1 write-data valid.
- AWREADY, WREADY  in  1  readys from the addressed slave.
- WLAST  in  1  muxed WLAST.
- BVALID  in  1  write-response valid from the slave.
- BREADY  in  1  muxed BREADY.
- CS_R, NS_R  out  4  read FSM current (registered) / next (combinational) state.
- CS_W, NS_W  out  4  write FSM current (registered) / next (combinational) state.

Behaviour:
- State codes are shared with the mux:
  - IDLE 0, ReadAddr_M1 1, ReadData_M1S0 2, ReadData_M1S1 3, ReadAddr_M0 4, ReadData_M0S0 5, ReadData_M0S1 6
  - WriteAddr_M1 7, WriteData_M1S0 8, WriteData_M1S1 9, WriteResp_S0M1 10, WriteResp_S1M1 11
  - WriteAddr_M0 12 (reserved, never entered), Default_Slave 13, Write_Addr_Data_M1S0 14, Write_Addr_Data_M1S1 15
- Reset: CS_R=CS_W=IDLE, last_rd_grant=M1, so M0 wins the first contention. NS_* follow combinationally from inputs.
- Read FSM:
  - IDLE: one requester → ReadAddr_Mx. Both requesting → grant the master not in last_rd_grant (round-robin), and update last_rd_grant on entry. No request → stay.
  - ReadAddr_Mx: on ARVALID&ARREADY, decode ARADDR_Mx → ReadData_MxS0, ReadData_MxS1, or Default_Slave. Otherwise hold. ARVALID dropping without handshake also holds.
  - ReadData_* / Default_Slave (read): → IDLE on RVALID&RREADY&RLAST; non-last beats hold.
  - Read-to-read minimum turnaround: one IDLE cycle.
- Write FSM (M1 only):
  - IDLE: AWVALID_M1&WVALID_M1 → Write_Addr_Data_M1Sx, with Sx decoded from AWADDR_M1; a miss → Default_Slave. AWVALID_M1 alone → WriteAddr_M1.
  - WriteAddr_M1: on AWVALID&AWREADY, decode → WriteData_M1Sx or Default_Slave.
  - Write_Addr_Data_M1Sx:
    - AWREADY&WREADY&WLAST → WriteResp_SxM1.
    - AWREADY only → WriteData_M1Sx.
    - Otherwise hold; data beats accepted before AWREADY are not allowed, so WREADY without AWREADY is ignored.
  - WriteData_M1Sx: WVALID&WREADY&WLAST → WriteResp_SxM1.
  - WriteResp_SxM1: BVALID&BREADY → IDLE.
  - Default_Slave (write): holds through the W beats; exits to IDLE on BVALID&BREADY (DECERR supplied by the default slave).
- The read and write FSMs are fully independent; simultaneous read and write to the same slave are permitted.
- Reset asserted mid-transaction forces both FSMs to IDLE asynchronously; no pending handshake is remembered.
- No combinational path from NS_* back into the FSM inputs.

Decomposition:
- Package axi_arb_pkg holds:
  - state enum / localparams for the 16 codes
  - S0/S1 window size constant
  - function decode_slave(addr) returning {S0,S1,DEF}
- Natural sub-module: axi_rd_rr_grant, a 2-way round-robin picker holding last_rd_grant.
- The write FSM stays inline.

Test Plan:
- Reset then ARVALID_M0=1, ARADDR_M0=32'h0000_0010, ARREADY at cycle 2 → CS_R 0→4→5. A 4-beat burst with RLAST on beat 4 → CS_R=0 the cycle after.
- ARVALID_M0 and ARVALID_M1 both held for three back-to-back single-beat reads → grants M0, M1, M0 (CS_R 4, then 1, then 4).
- ARVALID_M1, ARADDR_M1=32'h0001_0004 → ReadData_M1S1 (3). ARADDR_M1=32'h0005_0000 → Default_Slave (13), exits on RLAST handshake.
- AWVALID_M1=WVALID_M1=1, AWADDR 32'h0000_0100, AWREADY=WREADY=WLAST=1 same cycle → CS_W 0→14→10, then BVALID&BREADY → 0.
- AWVALID_M1 only, AWADDR 32'h0001_0000 → 7→9. A 2-beat W burst → 11 after WLAST; BVALID held low 5 cycles → CS_W holds 11.
- Assert ARESET while CS_R=5 and CS_W=9 → both read 0 immediately, before the next ACLK edge; after release, the first contention grants M0.
